// File: rtl/video_timing_aligner_if.sv
// Upstream pixel stream: RGB888 payload with frame-start marker and valid/ready handshake.
interface video_timing_aligner_if;
  localparam int unsigned PIX_W = 24;

  logic [PIX_W-1:0] pixel_data;
  logic             pixel_first;
  logic             pixel_valid;
  logic             pixel_ready;

  // Upstream line buffer drives the payload.
  modport master (
    output pixel_data,
    output pixel_first,
    output pixel_valid,
    input  pixel_ready
  );

  // Timing aligner consumes the payload.
  modport slave (
    input  pixel_data,
    input  pixel_first,
    input  pixel_valid,
    output pixel_ready
  );
endinterface

// File: rtl/video_timing_aligner.sv
// Raster timing generator that locks an upstream pixel stream to raster (0,0),
// blanks on underflow/misalignment and resynchronises on the next frame start.
module video_timing_aligner #(
  parameter int unsigned H_ACTIVE         = 1280,
  parameter int unsigned H_FP             = 110,
  parameter int unsigned H_SYNC           = 40,
  parameter int unsigned H_BP             = 220,
  parameter int unsigned V_ACTIVE         = 720,
  parameter int unsigned V_FP             = 5,
  parameter int unsigned V_SYNC           = 5,
  parameter int unsigned V_BP             = 20,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b1,
  parameter int unsigned CW               = 12,
  // Width of the internal event counter; it saturates at all-ones of this width.
  parameter int unsigned UF_CW            = 16
) (
  input  logic                         clock_video,
  input  logic                         reset_n,
  video_timing_aligner_if.slave        pix,
  output logic [23:0]                  video_data,
  output logic                         video_hsync,
  output logic                         video_vsync,
  output logic                         video_de,
  output logic                         data_in_sync,
  output logic [15:0]                  underflow_count
);

  localparam int unsigned PIX_W = 24;
  localparam int unsigned HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [UF_CW-1:0] UF_MAX = '1;

  typedef enum logic [1:0] {
    ST_DRAIN      = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_SYNCED     = 2'd2
  } state_e;

  // Registered state
  state_e             state_q,      state_d;
  logic [CW-1:0]      h_q,          h_d;
  logic [CW-1:0]      v_q,          v_d;
  logic [PIX_W-1:0]   video_data_q, video_data_d;
  logic               hsync_q,      hsync_d;
  logic               vsync_q,      vsync_d;
  logic               de_q,         de_d;
  logic               sync_q,       sync_d;
  logic [UF_CW-1:0]   uf_count_q,   uf_count_d;

  // Combinational helpers
  logic               active_c;
  logic               origin_c;
  logic               ready_c;
  logic               uf_event_c;
  logic               first_valid_c;

  // Raster position decode for the cycle currently held in the counters.
  always_comb begin
    active_c      = (h_q < H_ACT) && (v_q < V_ACT);
    origin_c      = (h_q == '0) && (v_q == '0);
    first_valid_c = pix.pixel_valid && pix.pixel_first;
  end

  // Raster counters: h wraps at HT-1, v advances on h wrap and wraps at VT-1.
  always_comb begin
    h_d = h_q + CW'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
    end
  end

  // Upstream ready: drain everything but a frame start, wait for (0,0), or take active pixels.
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      ST_DRAIN:      ready_c = !first_valid_c;
      ST_WAIT_FRAME: ready_c = origin_c;
      ST_SYNCED:     ready_c = active_c && !(first_valid_c && !origin_c);
      default:       ready_c = 1'b0;
    endcase
    if (!reset_n) begin
      ready_c = 1'b0;
    end
  end

  assign pix.pixel_ready = ready_c;

  // Lock state machine plus pixel/data-enable selection for the next output cycle.
  // video_de is asserted only for active slots that belong to a locked frame, so the
  // pin mux never sees a data-enable while the stream is being drained or awaited.
  always_comb begin
    state_d      = state_q;
    video_data_d = '0;
    de_d         = 1'b0;
    uf_event_c   = 1'b0;
    case (state_q)
      ST_DRAIN: begin
        if (first_valid_c) begin
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (origin_c && pix.pixel_valid) begin
          state_d      = ST_SYNCED;
          de_d         = 1'b1;
          video_data_d = pix.pixel_data;
        end
      end
      ST_SYNCED: begin
        if (active_c) begin
          de_d = 1'b1;
          if (!pix.pixel_valid) begin
            uf_event_c = 1'b1;
            state_d    = ST_DRAIN;
          end else if (pix.pixel_first && !origin_c) begin
            // Early frame start: leave it pending for the next (0,0).
            uf_event_c = 1'b1;
            state_d    = ST_WAIT_FRAME;
          end else begin
            video_data_d = pix.pixel_data;
            if (origin_c && !pix.pixel_first) begin
              // Frame boundary missing its start marker: show it, then realign.
              uf_event_c = 1'b1;
              state_d    = ST_DRAIN;
            end
          end
        end
      end
      default: begin
        state_d = ST_DRAIN;
      end
    endcase
  end

  // Sync pulses, lock indication and saturating event counter.
  always_comb begin
    hsync_d    = ((h_q >= HS_BEG) && (h_q < HS_END)) ? SYNC_ACTIVE_HIGH : !SYNC_ACTIVE_HIGH;
    vsync_d    = ((v_q >= VS_BEG) && (v_q < VS_END)) ? SYNC_ACTIVE_HIGH : !SYNC_ACTIVE_HIGH;
    sync_d     = (state_d == ST_SYNCED);
    uf_count_d = uf_count_q;
    if (uf_event_c && (uf_count_q != UF_MAX)) begin
      uf_count_d = uf_count_q + UF_CW'(1);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock_video) begin
    if (!reset_n) begin
      state_q      <= ST_DRAIN;
      h_q          <= '0;
      v_q          <= '0;
      video_data_q <= '0;
      hsync_q      <= !SYNC_ACTIVE_HIGH;
      vsync_q      <= !SYNC_ACTIVE_HIGH;
      de_q         <= 1'b0;
      sync_q       <= 1'b0;
      uf_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      video_data_q <= video_data_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      sync_q       <= sync_d;
      uf_count_q   <= uf_count_d;
    end
  end

  assign video_data      = video_data_q;
  assign video_hsync     = hsync_q;
  assign video_vsync     = vsync_q;
  assign video_de        = de_q;
  assign data_in_sync    = sync_q;
  assign underflow_count = 16'(uf_count_q);

endmodule
